// File: rtl/sram_skew_feeder.sv
// Start-triggered activation SRAM read sequencer. Each word is fanned out to
// the PE rows with lane k delayed k extra cycles (diagonal skew).

module sram_skew_lane #(
  parameter int W     = 8,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  output logic [W-1:0] out_data,
  output logic         pend
);
  logic [DEPTH-1:0]        vld_q, vld_d;
  logic [DEPTH-1:0][W-1:0] dat_q, dat_d;

  // Data is zeroed on entry when invalid, so empty stages always carry 0.
  always_comb begin
    vld_d    = '0;
    dat_d    = '0;
    pend     = 1'b0;
    vld_d[0] = in_vld;
    dat_d[0] = in_vld ? in_data : '0;
    for (int j = 1; j < DEPTH; j++) begin
      vld_d[j] = vld_q[j-1];
      dat_d[j] = dat_q[j-1];
    end
    for (int j = 0; j < DEPTH-1; j++) pend = pend | vld_q[j];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign out_vld  = vld_q[DEPTH-1];
  assign out_data = dat_q[DEPTH-1];
endmodule

module sram_skew_feeder #(
  parameter int ADDRESSSIZE = 10,
  parameter int WEIGHT_BW   = 8,
  parameter int NUM_PE_ROWS = 8,
  parameter int WORDSIZE    = WEIGHT_BW*NUM_PE_ROWS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDRESSSIZE-1:0] base_addr,
  input  logic [ADDRESSSIZE:0]   num_rows,
  output logic                   sram_read_en,
  output logic [ADDRESSSIZE-1:0] sram_address,
  input  logic [WORDSIZE-1:0]    sram_data_out,
  output logic [WORDSIZE-1:0]    lane_data,
  output logic [NUM_PE_ROWS-1:0] lane_valid,
  output logic                   busy,
  output logic                   done
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [ADDRESSSIZE-1:0] addr_q, addr_d;
  logic [ADDRESSSIZE:0]   cnt_q, cnt_d, nrows_q, nrows_d;
  logic                   rd_en_q, rd_en_d, rvld_q, rvld_d;
  logic                   busy_q, busy_d, done_q, done_d;
  logic [NUM_PE_ROWS-1:0] pend;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    nrows_d = nrows_q;
    rd_en_d = rd_en_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rvld_d  = rd_en_q;  // SRAM data returns one cycle after the strobe
    unique case (state_q)
      IDLE: if (start) begin
        if (num_rows != '0) begin
          nrows_d = num_rows;
          addr_d  = base_addr;
          cnt_d   = {{ADDRESSSIZE{1'b0}}, 1'b1};
          rd_en_d = 1'b1;
          busy_d  = 1'b1;
          state_d = ISSUE;
        end else begin
          done_d  = 1'b1;
        end
      end
      ISSUE: begin
        if (cnt_q == nrows_q) begin
          rd_en_d = 1'b0;
          state_d = DRAIN;
        end else begin
          addr_d  = addr_q + 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        // Last lane drains last; nothing left upstream means final row is out.
        if (lane_valid[NUM_PE_ROWS-1] && !(|pend) && !rvld_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      nrows_q <= '0;
      rd_en_q <= 1'b0;
      rvld_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      nrows_q <= nrows_d;
      rd_en_q <= rd_en_d;
      rvld_q  <= rvld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  for (genvar k = 0; k < NUM_PE_ROWS; k++) begin : g_lane
    sram_skew_lane #(.W(WEIGHT_BW), .DEPTH(k+1)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .in_vld   (rvld_q),
      .in_data  (sram_data_out[k*WEIGHT_BW +: WEIGHT_BW]),
      .out_vld  (lane_valid[k]),
      .out_data (lane_data[k*WEIGHT_BW +: WEIGHT_BW]),
      .pend     (pend[k])
    );
  end

  assign sram_read_en = rd_en_q;
  assign sram_address = addr_q;
  assign busy         = busy_q;
  assign done         = done_q;
endmodule
